// File: rtl/uart_bus_master_pkg.sv
// Shared constants and state encoding for the UART-driven bus initiator.
// Imported by the top-level FSM.
package uart_bus_master_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_BUS  = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_bus_master.sv
// Byte-stream command decoder that issues single-word reads/writes on the
// picorv32 native memory bus and streams replies back out over UART.
module uart_bus_master
   import uart_bus_master_pkg::*;
#(
   parameter int BUS_TIMEOUT  = 1024,
   parameter int BYTE_TIMEOUT = 5_000_000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int CNT_W = $clog2(max_int(BUS_TIMEOUT, BYTE_TIMEOUT) + 1);
   localparam logic [CNT_W-1:0] BUS_LAST  = CNT_W'(BUS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_TIMEOUT - 1);

   state_t           r_state,     w_state_next;
   logic             r_is_write,  w_is_write_next;
   logic [1:0]       r_byte_cnt,  w_byte_cnt_next;
   logic [CNT_W-1:0] r_cnt,       w_cnt_next;
   logic [29:0]      r_addr_hi,   w_addr_hi_next;
   logic [31:0]      r_wdata,     w_wdata_next;
   logic [31:0]      r_tx_sr,     w_tx_sr_next;
   logic [1:0]       r_tx_left,   w_tx_left_next;

   logic w_rx_fire;
   logic w_tx_fire;

   assign rx_ready  = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_DATA);
   assign tx_valid  = (r_state == ST_RESP);
   assign tx_data   = tx_valid ? r_tx_sr[7:0] : 8'h00;
   assign mem_valid = (r_state == ST_BUS);
   assign mem_addr  = {r_addr_hi, 2'b00};
   assign mem_wdata = r_wdata;
   assign mem_wstrb = (mem_valid && r_is_write) ? 4'hF : 4'h0;
   assign busy      = (r_state != ST_IDLE);

   assign w_rx_fire = rx_valid && rx_ready;
   assign w_tx_fire = tx_valid && tx_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_is_write <= 1'b0;
         r_byte_cnt <= '0;
         r_cnt      <= '0;
         r_addr_hi  <= '0;
         r_wdata    <= '0;
         r_tx_sr    <= '0;
         r_tx_left  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_is_write <= w_is_write_next;
         r_byte_cnt <= w_byte_cnt_next;
         r_cnt      <= w_cnt_next;
         r_addr_hi  <= w_addr_hi_next;
         r_wdata    <= w_wdata_next;
         r_tx_sr    <= w_tx_sr_next;
         r_tx_left  <= w_tx_left_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_is_write_next = r_is_write;
      w_byte_cnt_next = r_byte_cnt;
      w_cnt_next      = r_cnt;
      w_addr_hi_next  = r_addr_hi;
      w_wdata_next    = r_wdata;
      w_tx_sr_next    = r_tx_sr;
      w_tx_left_next  = r_tx_left;

      case (r_state)
         ST_IDLE: begin
            if (w_rx_fire) begin
               w_byte_cnt_next = '0;
               w_cnt_next      = '0;
               if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                  w_is_write_next = (rx_data == OP_WRITE);
                  w_state_next    = ST_ADDR;
               end else begin
                  w_tx_sr_next   = {24'h0, RSP_NAK};
                  w_tx_left_next = 2'd0;
                  w_state_next   = ST_RESP;
               end
            end
         end

         ST_ADDR: begin
            if (w_rx_fire) begin
               // Only address bits [31:2] are kept; the low two fall off the end of the shift.
               w_addr_hi_next  = {rx_data, r_addr_hi[29:8]};
               w_cnt_next      = '0;
               w_byte_cnt_next = r_byte_cnt + 2'd1;
               if (r_byte_cnt == 2'd3) begin
                  w_state_next = r_is_write ? ST_DATA : ST_BUS;
               end
            end else if (r_cnt == BYTE_LAST) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end

         ST_DATA: begin
            if (w_rx_fire) begin
               w_wdata_next    = {rx_data, r_wdata[31:8]};
               w_cnt_next      = '0;
               w_byte_cnt_next = r_byte_cnt + 2'd1;
               if (r_byte_cnt == 2'd3) begin
                  w_state_next = ST_BUS;
               end
            end else if (r_cnt == BYTE_LAST) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end

         ST_BUS: begin
            if (mem_ready) begin
               w_tx_sr_next   = r_is_write ? {24'h0, RSP_ACK} : mem_rdata;
               w_tx_left_next = r_is_write ? 2'd0 : 2'd3;
               w_state_next   = ST_RESP;
            end else if (r_cnt == BUS_LAST) begin
               w_tx_sr_next   = {24'h0, RSP_NAK};
               w_tx_left_next = 2'd0;
               w_state_next   = ST_RESP;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end

         ST_RESP: begin
            if (w_tx_fire) begin
               w_tx_sr_next   = {8'h00, r_tx_sr[31:8]};
               w_tx_left_next = r_tx_left - 2'd1;
               if (r_tx_left == 2'd0) begin
                  w_state_next = ST_IDLE;
               end
            end
         end

         default: w_state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench: spec vectors, hand-written timeout/backpressure/reset
// sequences, and randomized frames checked against a frame-level model.
module tb_uart_bus_master;

   localparam int BUS_TO  = 40;
   localparam int BYTE_TO = 60;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        busy;

   always #5 clk = ~clk;

   uart_bus_master #(.BUS_TIMEOUT(BUS_TO), .BYTE_TIMEOUT(BYTE_TO)) dut (
      .clk(clk), .resetn(resetn),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_t;

   typedef struct {
      int          nbus;   // mem_valid pulses
      int          nxfer;  // completed handshakes
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          nrep;
      logic [31:0] rep;    // reply bytes, first byte in [7:0]
   } exp_t;

   typedef struct {
      logic [71:0] frame;  // byte 0 in [7:0]
      int          len;
      logic [31:0] rdata;
      int          lat;
      exp_t        e;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // responder / tx sink controls, written only by the main process
   logic [31:0] rsp_rdata = 32'h0;
   int          rsp_lat = 0;
   logic        rsp_hang = 1'b0;
   logic        tx_hold = 1'b0;

   // observations, written only by the monitor
   bus_t        mem_log[$];
   logic [7:0]  tx_log[$];
   int          mv_cycles = 0;
   int          mv_rises = 0;
   int          stab_err = 0;
   logic        mv_prev = 1'b0;
   bus_t        held = '0;

   always @(negedge clk) begin
      if (mem_valid && mem_ready) mem_log.push_back({mem_addr, mem_wdata, mem_wstrb});
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (mem_valid) mv_cycles <= mv_cycles + 1;
      if (mem_valid && !mv_prev) begin
         mv_rises <= mv_rises + 1;
         held <= {mem_addr, mem_wdata, mem_wstrb};
      end else if (mem_valid && (held != {mem_addr, mem_wdata, mem_wstrb})) begin
         stab_err <= stab_err + 1;
      end
      mv_prev <= mem_valid;
   end

   // Bus responder and tx sink; idle-time mem_ready/mem_rdata are junk on purpose.
   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (!mem_valid) begin
            wcnt = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end else if (!rsp_hang && wcnt >= rsp_lat) begin
            mem_ready = 1'b1;
            mem_rdata = rsp_rdata;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            wcnt++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [71:0] f, input logic [31:0] rdata);
      exp_t e;
      e.nbus = 0; e.nxfer = 0; e.addr = 32'h0; e.wdata = 32'h0; e.wstrb = 4'h0;
      e.nrep = 1; e.rep = 32'h15;
      if (f[7:0] == 8'h57) begin
         e.nbus = 1; e.nxfer = 1;
         e.addr = f[39:8] & 32'hFFFF_FFFC;
         e.wdata = f[71:40];
         e.wstrb = 4'hF;
         e.rep = 32'h06;
      end else if (f[7:0] == 8'h52) begin
         e.nbus = 1; e.nxfer = 1;
         e.addr = f[39:8] & 32'hFFFF_FFFC;
         e.nrep = 4;
         e.rep = rdata;
      end
      return e;
   endfunction

   function automatic int flen(input logic [7:0] op);
      return (op == 8'h57) ? 9 : (op == 8'h52) ? 5 : 1;
   endfunction

   function automatic vec_t mkv(input logic [71:0] f, input int len, input logic [31:0] rdata,
                                input int lat, input int nbus, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int nrep, input logic [31:0] rep);
      vec_t v;
      v.frame = f; v.len = len; v.rdata = rdata; v.lat = lat;
      v.e.nbus = nbus; v.e.nxfer = nbus; v.e.addr = addr; v.e.wdata = wdata;
      v.e.wstrb = wstrb; v.e.nrep = nrep; v.e.rep = rep;
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b, input string tag);
      logic got;
      got = 1'b0;
      rx_data = b;
      rx_valid = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (rx_ready) got = 1'b1;
         @(posedge clk);
         #1;
         if (got) break;
      end
      rx_valid = 1'b0;
      check({tag, " rx accepted"}, 32'(got), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check({tag, " returned idle"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input int tb0, input int mb0, input int r0,
                               input int s0, input exp_t e);
      bus_t t;
      check({tag, " bus pulses"}, mv_rises - r0, e.nbus);
      check({tag, " bus xfers"}, mem_log.size() - mb0, e.nxfer);
      if (e.nxfer == 1 && mem_log.size() > mb0) begin
         t = mem_log[mb0];
         check({tag, " addr"}, t.addr, e.addr);
         check({tag, " wstrb"}, 32'(t.wstrb), 32'(e.wstrb));
         if (e.wstrb == 4'hF) check({tag, " wdata"}, t.wdata, e.wdata);
      end
      check({tag, " bus stable"}, stab_err - s0, 0);
      check({tag, " reply count"}, tx_log.size() - tb0, e.nrep);
      for (int i = 0; i < e.nrep && (tb0 + i) < tx_log.size(); i++)
         check({tag, $sformatf(" reply[%0d]", i)}, 32'(tx_log[tb0 + i]), 32'(e.rep[8*i +: 8]));
   endtask

   task automatic run_frame(input string tag, input logic [71:0] f, input int len,
                            input logic [31:0] rdata, input int lat, input int gapmax,
                            input exp_t e);
      int tb0, mb0, r0, s0, g;
      rsp_rdata = rdata;
      rsp_lat = lat;
      tb0 = tx_log.size(); mb0 = mem_log.size(); r0 = mv_rises; s0 = stab_err;
      for (int i = 0; i < len; i++) begin
         g = $urandom_range(0, gapmax);
         repeat (g) begin @(posedge clk); #1; end
         send_byte(f[8*i +: 8], tag);
      end
      wait_idle(tag);
      check_result(tag, tb0, mb0, r0, s0, e);
      $display("%s: op=%02h addr=%08h nrep=%0d lat=%0d", tag, f[7:0], e.addr, e.nrep, lat);
   endtask

   initial begin
      vec_t        vecs[6];
      exp_t        e;
      logic [71:0] f;
      logic [31:0] rd;
      logic [7:0]  op;
      int          tb0, mb0, r0, s0, c0, bad;

      vecs[0] = mkv(72'hDEADBEEF_00002010_57, 9, 32'h0, 3, 1, 32'h00002010, 32'hDEADBEEF, 4'hF, 1, 32'h06);
      vecs[1] = mkv(72'h00000000_02000000_52, 5, 32'h00000033, 0, 1, 32'h02000000, 32'h0, 4'h0, 4, 32'h00000033);
      vecs[2] = mkv(72'h41, 1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h15);
      vecs[3] = mkv(72'h12345678_80000007_57, 9, 32'h0, 1, 1, 32'h80000004, 32'h12345678, 4'hF, 1, 32'h06);
      vecs[4] = mkv(72'h00000000_FFFFFFFF_52, 5, 32'hA5C30F1E, 5, 1, 32'hFFFFFFFC, 32'h0, 4'h0, 4, 32'hA5C30F1E);
      vecs[5] = mkv(72'h00, 1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h15);

      #2 resetn = 1'b0;
      #1;
      check("reset rx_ready", 32'(rx_ready), 32'd1);
      check("reset tx_valid", 32'(tx_valid), 32'd0);
      check("reset mem_valid", 32'(mem_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset mem_wdata", mem_wdata, 32'd0);
      check("reset tx_data", 32'(tx_data), 32'd0);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].len, vecs[i].rdata,
                   vecs[i].lat, 2, vecs[i].e);

      // bus timeout: mem_valid held exactly BUS_TO cycles, then NAK
      rsp_hang = 1'b1;
      c0 = mv_cycles;
      e = model(72'h00000000_00001000_52, 32'h0);
      e.nxfer = 0; e.nrep = 1; e.rep = 32'h15;
      run_frame("bus_timeout", 72'h00000000_00001000_52, 5, 32'h0, 0, 0, e);
      check("bus_timeout valid cycles", mv_cycles - c0, BUS_TO);
      rsp_hang = 1'b0;

      // byte timeout: partial frame discarded exactly BYTE_TO idle cycles after last byte
      tb0 = tx_log.size(); r0 = mv_rises;
      send_byte(8'h57, "byte_timeout");
      send_byte(8'h34, "byte_timeout");
      send_byte(8'h12, "byte_timeout");
      repeat (BYTE_TO - 1) begin @(posedge clk); #1; end
      check("byte_timeout busy before limit", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("byte_timeout busy at limit", 32'(busy), 32'd0);
      check("byte_timeout no reply", tx_log.size() - tb0, 0);
      check("byte_timeout no bus", mv_rises - r0, 0);
      $display("byte_timeout: partial frame dropped");
      f = 72'hCAFEF00D_00000124_57;
      run_frame("after_byte_timeout", f, 9, 32'h0, 2, 1, model(f, 32'h0));

      // tx backpressure: tx_data must hold while tx_ready stays low
      tx_hold = 1'b1;
      rsp_rdata = 32'hC0FFEE5A;
      rsp_lat = 2;
      tb0 = tx_log.size(); mb0 = mem_log.size(); r0 = mv_rises; s0 = stab_err;
      f = 72'h00000000_00000040_52;
      for (int i = 0; i < 5; i++) send_byte(f[8*i +: 8], "backpressure");
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (tx_valid) break;
      end
      check("backpressure tx_valid", 32'(tx_valid), 32'd1);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (!tx_valid || tx_data !== 8'h5A) bad++;
      end
      check("backpressure tx stable", bad, 0);
      tx_hold = 1'b0;
      @(posedge clk);
      #1;
      wait_idle("backpressure");
      check_result("backpressure", tb0, mb0, r0, s0, model(f, 32'hC0FFEE5A));
      $display("backpressure: read addr=00000040 held 100 cycles");

      // async reset in the middle of a bus transfer
      rsp_hang = 1'b1;
      f = 72'h44332211_00000100_57;
      for (int i = 0; i < 9; i++) send_byte(f[8*i +: 8], "reset_mid_bus");
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mem_valid) break;
      end
      check("reset_mid_bus mem_valid before", 32'(mem_valid), 32'd1);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      check("reset_mid_bus mem_valid", 32'(mem_valid), 32'd0);
      check("reset_mid_bus tx_valid", 32'(tx_valid), 32'd0);
      check("reset_mid_bus busy", 32'(busy), 32'd0);
      check("reset_mid_bus mem_addr", mem_addr, 32'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      rsp_hang = 1'b0;
      @(posedge clk);
      #1;
      check("reset_mid_bus rx_ready", 32'(rx_ready), 32'd1);
      $display("reset_mid_bus: transfer aborted");
      f = 72'h00000000_00000100_52;
      run_frame("after_reset", f, 5, 32'h0BADF00D, 1, 1, model(f, 32'h0BADF00D));

      // randomized frames against the frame-level model
      for (int n = 0; n < 40; n++) begin
         f = {8'($urandom), $urandom, $urandom};
         case ($urandom_range(0, 9))
            0, 1, 2, 3: op = 8'h57;
            4, 5, 6, 7: op = 8'h52;
            default: begin
               op = 8'($urandom_range(0, 255));
               while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
            end
         endcase
         f[7:0] = op;
         rd = $urandom;
         run_frame($sformatf("rand%0d", n), f, flen(op), rd, $urandom_range(0, 6), 3, model(f, rd));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
